// File: rtl/tx_mac_arbiter.sv
// Two-port AXI-Stream frame arbiter for the TX MAC: whole-frame grants, round-robin ties,
// and a speed-scaled inter-frame gap. Define TX_ARB_STRICT_PRIO_EN for strict port-0 priority.
module tx_mac_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int IFG_BYTES  = 12,
   parameter int IFG_CNT_W  = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  mii_select,
   input  logic [DATA_WIDTH-1:0] s0_tx_axis_tdata,
   input  logic                  s0_tx_axis_tvalid,
   input  logic                  s0_tx_axis_tlast,
   input  logic                  s0_tx_axis_tkeep,
   input  logic                  s0_tx_axis_tuser,
   output logic                  s0_tx_axis_trdy,
   input  logic [DATA_WIDTH-1:0] s1_tx_axis_tdata,
   input  logic                  s1_tx_axis_tvalid,
   input  logic                  s1_tx_axis_tlast,
   input  logic                  s1_tx_axis_tkeep,
   input  logic                  s1_tx_axis_tuser,
   output logic                  s1_tx_axis_trdy,
   output logic [DATA_WIDTH-1:0] m_tx_axis_tdata,
   output logic                  m_tx_axis_tvalid,
   output logic                  m_tx_axis_tlast,
   output logic                  m_tx_axis_tkeep,
   output logic                  m_tx_axis_tuser,
   input  logic                  m_tx_axis_trdy,
   output logic [1:0]            grant,
   output logic                  busy,
   output logic [1:0]            dbg_state_o
);

   // Handshake: a beat moves when tvalid and trdy are both high at a clk edge; the
   // granted source sees the MAC's trdy directly, so stalls hold the source's data.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_IFG  = 2'd2
   } state_t;

   localparam logic [IFG_CNT_W-1:0] IFG_LOAD = IFG_CNT_W'(IFG_BYTES);
   localparam logic [IFG_CNT_W-1:0] CNT_ONE  = IFG_CNT_W'(1);

   state_t               state_q, state_d;
   logic [1:0]           grant_q, grant_d;
   logic                 rr_q, rr_d;       // port index that wins the next tie
   logic [IFG_CNT_W-1:0] cnt_q, cnt_d;
   logic                 phase_q, phase_d;
   logic                 pick1;
   logic                 g_valid;
   logic                 g_last;
   logic                 frame_end;
   logic                 dec;

   assign g_valid   = (grant_q[0] & s0_tx_axis_tvalid) | (grant_q[1] & s1_tx_axis_tvalid);
   assign g_last    = (grant_q[0] & s0_tx_axis_tlast)  | (grant_q[1] & s1_tx_axis_tlast);
   assign frame_end = (state_q == ST_XFER) & g_valid & g_last & m_tx_axis_trdy;
   // 10/100 mode spends two clocks per byte time: decrement on the second phase only.
   assign dec       = ~mii_select | phase_q;

`ifdef TX_ARB_STRICT_PRIO_EN
   assign pick1 = ~s0_tx_axis_tvalid;
`else
   assign pick1 = s1_tx_axis_tvalid & (~s0_tx_axis_tvalid | rr_q);
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         grant_q <= 2'b00;
         rr_q    <= 1'b0;
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      case (state_q)
         ST_IDLE: begin
            if (s0_tx_axis_tvalid || s1_tx_axis_tvalid) begin
               grant_d = pick1 ? 2'b10 : 2'b01;
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            if (frame_end) begin
               rr_d    = grant_q[0];
               grant_d = 2'b00;
               phase_d = 1'b0;
               if (IFG_BYTES == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_IFG;
                  cnt_d   = IFG_LOAD;
               end
            end
         end
         ST_IFG: begin
            phase_d = mii_select ? ~phase_q : 1'b0;
            if (dec) begin
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   always_comb begin
      m_tx_axis_tdata  = '0;
      m_tx_axis_tvalid = 1'b0;
      m_tx_axis_tlast  = 1'b0;
      m_tx_axis_tkeep  = 1'b0;
      m_tx_axis_tuser  = 1'b0;
      s0_tx_axis_trdy  = 1'b0;
      s1_tx_axis_trdy  = 1'b0;
      if (state_q == ST_XFER) begin
         if (grant_q[0]) begin
            m_tx_axis_tdata  = s0_tx_axis_tdata;
            m_tx_axis_tvalid = s0_tx_axis_tvalid;
            m_tx_axis_tlast  = s0_tx_axis_tlast;
            m_tx_axis_tkeep  = s0_tx_axis_tkeep;
            m_tx_axis_tuser  = s0_tx_axis_tuser;
            s0_tx_axis_trdy  = m_tx_axis_trdy;
         end else if (grant_q[1]) begin
            m_tx_axis_tdata  = s1_tx_axis_tdata;
            m_tx_axis_tvalid = s1_tx_axis_tvalid;
            m_tx_axis_tlast  = s1_tx_axis_tlast;
            m_tx_axis_tkeep  = s1_tx_axis_tkeep;
            m_tx_axis_tuser  = s1_tx_axis_tuser;
            s1_tx_axis_trdy  = m_tx_axis_trdy;
         end
      end
      grant       = grant_q;
      busy        = (state_q != ST_IDLE);
      dbg_state_o = state_q;
   end

endmodule

// File: tb/tb_tx_mac_arbiter.sv
// Directed bench for tx_mac_arbiter: cycle table for single-source, IFG and backpressure,
// plus hand sequences for contention, 10/100 gap, mid-frame reset and an IFG_BYTES=0 instance.
module tb_tx_mac_arbiter;

`ifdef TX_ARB_STRICT_PRIO_EN
   localparam bit STRICT = 1'b1;
`else
   localparam bit STRICT = 1'b0;
`endif

   logic       clk;
   logic       reset_n;
   logic       mii_select;
   logic [7:0] s0_tdata, s1_tdata, m_tdata;
   logic       s0_tvalid, s0_tlast, s0_tkeep, s0_tuser, s0_trdy;
   logic       s1_tvalid, s1_tlast, s1_tkeep, s1_tuser, s1_trdy;
   logic       m_tvalid, m_tlast, m_tkeep, m_tuser, m_trdy;
   logic [1:0] grant, dbg_state;
   logic       busy;

   logic [7:0] b_s0_tdata, b_s1_tdata, b_m_tdata;
   logic       b_s0_tvalid, b_s0_tlast, b_s0_tkeep, b_s0_tuser, b_s0_trdy;
   logic       b_s1_tvalid, b_s1_tlast, b_s1_tkeep, b_s1_tuser, b_s1_trdy;
   logic       b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tuser, b_m_trdy;
   logic [1:0] b_grant, b_dbg_state;
   logic       b_busy;

   tx_mac_arbiter #(.DATA_WIDTH(8), .IFG_BYTES(12), .IFG_CNT_W(5)) u_dut (
      .clk(clk), .reset_n(reset_n), .mii_select(mii_select),
      .s0_tx_axis_tdata(s0_tdata), .s0_tx_axis_tvalid(s0_tvalid), .s0_tx_axis_tlast(s0_tlast),
      .s0_tx_axis_tkeep(s0_tkeep), .s0_tx_axis_tuser(s0_tuser), .s0_tx_axis_trdy(s0_trdy),
      .s1_tx_axis_tdata(s1_tdata), .s1_tx_axis_tvalid(s1_tvalid), .s1_tx_axis_tlast(s1_tlast),
      .s1_tx_axis_tkeep(s1_tkeep), .s1_tx_axis_tuser(s1_tuser), .s1_tx_axis_trdy(s1_trdy),
      .m_tx_axis_tdata(m_tdata), .m_tx_axis_tvalid(m_tvalid), .m_tx_axis_tlast(m_tlast),
      .m_tx_axis_tkeep(m_tkeep), .m_tx_axis_tuser(m_tuser), .m_tx_axis_trdy(m_trdy),
      .grant(grant), .busy(busy), .dbg_state_o(dbg_state)
   );

   tx_mac_arbiter #(.DATA_WIDTH(8), .IFG_BYTES(0), .IFG_CNT_W(5)) u_dut_nogap (
      .clk(clk), .reset_n(reset_n), .mii_select(mii_select),
      .s0_tx_axis_tdata(b_s0_tdata), .s0_tx_axis_tvalid(b_s0_tvalid), .s0_tx_axis_tlast(b_s0_tlast),
      .s0_tx_axis_tkeep(b_s0_tkeep), .s0_tx_axis_tuser(b_s0_tuser), .s0_tx_axis_trdy(b_s0_trdy),
      .s1_tx_axis_tdata(b_s1_tdata), .s1_tx_axis_tvalid(b_s1_tvalid), .s1_tx_axis_tlast(b_s1_tlast),
      .s1_tx_axis_tkeep(b_s1_tkeep), .s1_tx_axis_tuser(b_s1_tuser), .s1_tx_axis_trdy(b_s1_trdy),
      .m_tx_axis_tdata(b_m_tdata), .m_tx_axis_tvalid(b_m_tvalid), .m_tx_axis_tlast(b_m_tlast),
      .m_tx_axis_tkeep(b_m_tkeep), .m_tx_axis_tuser(b_m_tuser), .m_tx_axis_trdy(b_m_trdy),
      .grant(b_grant), .busy(b_busy), .dbg_state_o(b_dbg_state)
   );

   typedef struct {
      logic       s0v, s0l;
      logic [7:0] s0d;
      logic       s1v, s1l;
      logic [7:0] s1d;
      logic       mrdy;
      logic [1:0] eg;
      logic       emv;
      logic [7:0] emd;
      logic       eml, es0r, es1r, ebusy;
   } vec_t;

   vec_t vt[$];
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Source tuser carries data parity so pass-through is visible; tkeep is always 1.
   task automatic drive(input logic v0, input logic l0, input logic [7:0] d0,
                        input logic v1, input logic l1, input logic [7:0] d1, input logic mr);
      s0_tvalid = v0; s0_tlast = l0; s0_tdata = d0; s0_tuser = ^d0; s0_tkeep = 1'b1;
      s1_tvalid = v1; s1_tlast = l1; s1_tdata = d1; s1_tuser = ^d1; s1_tkeep = 1'b1;
      m_trdy = mr;
   endtask

   task automatic add(input logic s0v, input logic s0l, input logic [7:0] s0d,
                      input logic s1v, input logic s1l, input logic [7:0] s1d, input logic mrdy,
                      input logic [1:0] eg, input logic emv, input logic [7:0] emd, input logic eml,
                      input logic es0r, input logic es1r, input logic ebusy);
      vec_t v;
      v.s0v = s0v; v.s0l = s0l; v.s0d = s0d; v.s1v = s1v; v.s1l = s1l; v.s1d = s1d;
      v.mrdy = mrdy; v.eg = eg; v.emv = emv; v.emd = emd; v.eml = eml;
      v.es0r = es0r; v.es1r = es1r; v.ebusy = ebusy;
      vt.push_back(v);
   endtask

   task automatic add_idle(input logic s1v, input logic s1l, input logic [7:0] s1d,
                           input logic ebusy, input int n);
      for (int k = 0; k < n; k++) add(0, 0, 8'h00, s1v, s1l, s1d, 1, 2'b00, 0, 8'h00, 0, 0, 0, ebusy);
   endtask

   task automatic wait_idle(input string name);
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         drive(0, 0, 8'h00, 0, 0, 8'h00, 1);
         #1;
         if (!busy && grant == 2'b00) break;
      end
      chk(name, busy, 0);
   endtask

   initial begin
      int         pend0, pend1, exp_p, w, gap, gap_busy, hs;
      logic       rr_m;
      logic [7:0] d;
      string      tag;

      // Single source, gigabit: 4-beat frame then a 12-cycle gap while port 1 waits.
      add(1, 0, 8'h11, 0, 0, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0, 0, 0);
      add(1, 0, 8'h11, 0, 0, 8'h00, 1, 2'b01, 1, 8'h11, 0, 1, 0, 1);
      add(1, 0, 8'h12, 0, 0, 8'h00, 1, 2'b01, 1, 8'h12, 0, 1, 0, 1);
      add(1, 0, 8'h13, 0, 0, 8'h00, 1, 2'b01, 1, 8'h13, 0, 1, 0, 1);
      add(1, 1, 8'h14, 0, 0, 8'h00, 1, 2'b01, 1, 8'h14, 1, 1, 0, 1);
      add_idle(1, 1, 8'h21, 1, 12);
      add(0, 0, 8'h00, 1, 1, 8'h21, 1, 2'b00, 0, 8'h00, 0, 0, 0, 0);
      add(0, 0, 8'h00, 1, 1, 8'h21, 1, 2'b10, 1, 8'h21, 1, 0, 1, 1);
      add_idle(0, 0, 8'h00, 1, 12);
      // Tie with pointer at port 0, a source bubble, then a 5-clk MAC stall on 0xA5.
      add(1, 0, 8'hA3, 1, 1, 8'hB1, 1, 2'b00, 0, 8'h00, 0, 0, 0, 0);
      add(1, 0, 8'hA3, 1, 1, 8'hB1, 1, 2'b01, 1, 8'hA3, 0, 1, 0, 1);
      add(1, 0, 8'hA4, 1, 1, 8'hB1, 1, 2'b01, 1, 8'hA4, 0, 1, 0, 1);
      add(0, 0, 8'hA4, 1, 1, 8'hB1, 1, 2'b01, 0, 8'hA4, 0, 1, 0, 1);
      for (int k = 0; k < 5; k++) add(1, 0, 8'hA5, 1, 1, 8'hB1, 0, 2'b01, 1, 8'hA5, 0, 0, 0, 1);
      add(1, 0, 8'hA5, 1, 1, 8'hB1, 1, 2'b01, 1, 8'hA5, 0, 1, 0, 1);
      add(1, 1, 8'hA6, 1, 1, 8'hB1, 1, 2'b01, 1, 8'hA6, 1, 1, 0, 1);
      add_idle(1, 1, 8'hB1, 1, 12);
      add(0, 0, 8'h00, 1, 1, 8'hB1, 1, 2'b00, 0, 8'h00, 0, 0, 0, 0);
      add(0, 0, 8'h00, 1, 1, 8'hB1, 1, 2'b10, 1, 8'hB1, 1, 0, 1, 1);
      add_idle(0, 0, 8'h00, 1, 12);
      add_idle(0, 0, 8'h00, 0, 1);

      // Reset with port 0 already requesting.
      mii_select = 1'b0;
      reset_n = 1'b0;
      drive(1, 0, 8'h11, 0, 0, 8'h00, 1);
      b_s0_tvalid = 0; b_s0_tlast = 0; b_s0_tdata = 8'h00; b_s0_tkeep = 1; b_s0_tuser = 0;
      b_s1_tvalid = 0; b_s1_tlast = 0; b_s1_tdata = 8'h00; b_s1_tkeep = 1; b_s1_tuser = 0;
      b_m_trdy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_grant", grant, 2'b00);
      chk("rst_busy", busy, 0);
      chk("rst_state", dbg_state, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_trdy", {s0_trdy, s1_trdy}, 0);
      chk("rst_nogap_grant", b_grant, 2'b00);

      for (int i = 0; i < vt.size(); i++) begin
         @(negedge clk);
         reset_n = 1'b1;
         drive(vt[i].s0v, vt[i].s0l, vt[i].s0d, vt[i].s1v, vt[i].s1l, vt[i].s1d, vt[i].mrdy);
         #1;
         tag = $sformatf("v%0d", i);
         chk({tag, "_grant"}, grant, vt[i].eg);
         chk({tag, "_m_tvalid"}, m_tvalid, vt[i].emv);
         chk({tag, "_m_tdata"}, m_tdata, vt[i].emd);
         chk({tag, "_m_tlast"}, m_tlast, vt[i].eml);
         chk({tag, "_m_tkeep"}, m_tkeep, |vt[i].eg);
         chk({tag, "_m_tuser"}, m_tuser, (|vt[i].eg) ? ^vt[i].emd : 1'b0);
         chk({tag, "_s0_trdy"}, s0_trdy, vt[i].es0r);
         chk({tag, "_s1_trdy"}, s1_trdy, vt[i].es1r);
         chk({tag, "_busy"}, busy, vt[i].ebusy);
      end

      // Contention: two 3-beat frames per port, both always requesting while pending.
      pend0 = 2; pend1 = 2; rr_m = 1'b0;
      for (int f = 0; f < 4; f++) begin
         exp_p = (pend0 > 0 && (pend1 == 0 || STRICT || rr_m == 1'b0)) ? 0 : 1;
         w = 0;
         do begin
            @(negedge clk);
            drive(pend0 > 0, 0, 8'h30 + 8'(8 * (2 - pend0)), pend1 > 0, 0, 8'h60 + 8'(8 * (2 - pend1)), 1);
            #1;
            w++;
         end while (grant == 2'b00 && w < 40);
         chk($sformatf("cont_f%0d_grant", f), grant, exp_p ? 2'b10 : 2'b01);
         for (int b = 0; b < 3; b++) begin
            if (b > 0) begin
               @(negedge clk);
               if (exp_p == 0)
                  drive(1, b == 2, 8'h30 + 8'(8 * (2 - pend0) + b), pend1 > 0, 0, 8'h60 + 8'(8 * (2 - pend1)), 1);
               else
                  drive(pend0 > 0, 0, 8'h30 + 8'(8 * (2 - pend0)), 1, b == 2, 8'h60 + 8'(8 * (2 - pend1) + b), 1);
               #1;
            end
            d = (exp_p == 0) ? 8'h30 + 8'(8 * (2 - pend0) + b) : 8'h60 + 8'(8 * (2 - pend1) + b);
            chk($sformatf("cont_f%0d_b%0d_tdata", f, b), m_tdata, d);
         end
         if (exp_p == 0) pend0--; else pend1--;
         rr_m = (exp_p == 0);
      end
      wait_idle("cont_drain");

      // 10/100 gap after a port 1 single-beat frame.
      mii_select = 1'b1;
      w = 0;
      do begin
         @(negedge clk);
         drive(0, 0, 8'h00, 1, 1, 8'h77, 1);
         #1;
         w++;
      end while (grant == 2'b00 && w < 10);
      chk("mii_p1_grant", grant, 2'b10);
      chk("mii_p1_tdata", m_tdata, 8'h77);
      gap = 0; gap_busy = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         drive(1, 1, 8'hE0, 0, 0, 8'h00, 1);
         #1;
         if (grant != 2'b00) break;
         gap++;
         if (busy) gap_busy++;
      end
      chk("mii_gap_cycles", gap, 25);
      chk("mii_gap_busy", gap_busy, 24);
      chk("mii_p0_grant", grant, 2'b01);
      chk("mii_p0_tdata", m_tdata, 8'hE0);
      mii_select = 1'b0;
      wait_idle("mii_drain");

      // Reset during beat 2 of a 5-beat port 0 frame; pointer was at port 1 beforehand.
      w = 0;
      do begin
         @(negedge clk);
         drive(1, 0, 8'hC1, 0, 0, 8'h00, 1);
         #1;
         w++;
      end while (grant == 2'b00 && w < 10);
      chk("rmf_grant", grant, 2'b01);
      @(negedge clk);
      drive(1, 0, 8'hC2, 0, 0, 8'h00, 1);
      #1;
      chk("rmf_beat1", m_tdata, 8'hC2);
      @(negedge clk);
      drive(1, 0, 8'hC3, 0, 0, 8'h00, 1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      drive(1, 1, 8'hC1, 1, 1, 8'hD1, 1);
      #1;
      chk("rmf_grant_clr", grant, 2'b00);
      chk("rmf_m_tvalid", m_tvalid, 0);
      chk("rmf_m_tlast", m_tlast, 0);
      chk("rmf_trdy", {s0_trdy, s1_trdy}, 0);
      chk("rmf_busy", busy, 0);
      chk("rmf_state", dbg_state, 0);
      @(negedge clk);
      #1;
      chk("rmf_tie_grant", grant, 2'b01);
      chk("rmf_tie_tdata", m_tdata, 8'hC1);
      @(negedge clk);
      drive(0, 0, 8'h00, 0, 0, 8'h00, 1);

      // No-gap instance: back-to-back single-beat frames, one every 2 clk.
      hs = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         b_s0_tvalid = 1'b1; b_s0_tlast = 1'b1; b_s0_tdata = 8'h5A; b_s0_tuser = ^8'h5A;
         #1;
         chk($sformatf("nogap_c%0d_grant", k), b_grant, (k % 2) ? 2'b01 : 2'b00);
         chk($sformatf("nogap_c%0d_busy", k), b_busy, k % 2);
         if (b_m_tvalid && b_m_trdy) hs++;
      end
      chk("nogap_frames", hs, 4);
      @(negedge clk);
      b_s0_tvalid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tx_mac_arbiter.md
Name: tx_mac_arbiter

Overview:
- Two-input AXI-Stream frame arbiter and scheduler in front of the TX MAC's s_tx_axis slave.
- Shares the single MAC transmit path between two frame sources (port 0 for the UDP/IP path, port 1 for ARP/control).
- Grants whole frames, round-robin by default, and locks the grant until tlast.
- After each frame, enforces a minimum inter-frame idle gap, counted in byte times, that scales with the MAC's MII/RGMII speed mode.

Parameters:
- DATA_WIDTH, 8, width of all tdata buses.
- IFG_BYTES, 12, minimum idle byte times between the accepted tlast and the next grant. 0 disables the gap.
- IFG_CNT_W, 5, width of the gap counter. Must satisfy 2^IFG_CNT_W > IFG_BYTES.

Ports:
- clk, input, 1, sole clock.
- reset_n, input, 1, synchronous active-low reset.
- mii_select, input, 1, speed mode. 1 = 10/100 mode (2 clk per byte); 0 = gigabit mode (1 clk per byte).
- s0_tx_axis_tdata, input, DATA_WIDTH, port 0 data.
- s0_tx_axis_tvalid, input, 1, port 0 valid.
- s0_tx_axis_tlast, input, 1, port 0 end of frame.
- s0_tx_axis_tkeep, input, 1, port 0 byte qualifier.
- s0_tx_axis_tuser, input, 1, port 0 error/abort flag.
- s0_tx_axis_trdy, output, 1, port 0 ready.
- s1_tx_axis_tdata, s1_tx_axis_tvalid, s1_tx_axis_tlast, s1_tx_axis_tkeep, s1_tx_axis_tuser, s1_tx_axis_trdy: port 1 signals, identical widths and directions to port 0.
- m_tx_axis_tdata, output, DATA_WIDTH, to MAC.
- m_tx_axis_tvalid, output, 1, to MAC.
- m_tx_axis_tlast, output, 1, to MAC.
- m_tx_axis_tkeep, output, 1, to MAC.
- m_tx_axis_tuser, output, 1, to MAC.
- m_tx_axis_trdy, input, 1, from MAC.
- grant, output, 2, one-hot registered grant. 00 = none.
- busy, output, 1, high in XFER or IFG.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE, grant=00, busy=0.
  - All m_* outputs 0 and both s*_trdy 0.
  - Gap counter 0; round-robin pointer set so port 0 wins the next tie.
- Reset asserted mid-frame aborts the frame immediately. No tlast is synthesized.
- FSM states: IDLE, XFER, IFG.
- IDLE:
  - If any s*_tvalid, register grant to the chosen port and move to XFER on the next edge.
  - If only one port is valid, it wins.
  - If both are valid, the port not granted last wins (round-robin).
  - Both s*_trdy=0 and m_tx_axis_tvalid=0 while in IDLE.
- XFER:
  - Zero-latency combinational mux. m_* data, tvalid, tlast, tkeep and tuser follow the granted port.
  - Granted s_trdy = m_tx_axis_trdy. Non-granted s_trdy = 0.
  - Grant holds regardless of the other port's tvalid.
  - A granted tvalid deasserting mid-frame does not release the grant.
- Frame end: on granted tvalid & tlast & m_tx_axis_trdy:
  - Update the round-robin pointer to the other port.
  - Clear grant.
  - Go to IFG, loading the counter with IFG_BYTES. If IFG_BYTES=0, go directly to IDLE.
- Latency: first beat of a new frame is presented at least 1 clk after tvalid is seen in IDLE. This is the arbitration cycle.
- IFG:
  - Both trdy=0, m_tx_axis_tvalid=0, busy=1.
  - Counter decrements by 1 each clk when mii_select=0.
  - Counter decrements every 2nd clk when mii_select=1, using a phase toggle that is cleared on IFG entry.
  - Exit to IDLE on the edge where the counter reaches 0. Gap = IFG_BYTES clk (gigabit) or 2*IFG_BYTES clk (10/100), excluding the arbitration cycle.
- mii_select is sampled continuously. A change during IFG takes effect on the next decrement.
- Backpressure: m_tx_axis_trdy low holds all m_* outputs stable, because the source must hold its data under AXI rules.
- Single-beat frame (tvalid & tlast on the first beat) is legal: XFER lasts 1 clk when the MAC is ready.
- tuser is passed through unchanged. The arbiter never drops or truncates frames.

Optional Feature:
- Macro: TX_ARB_STRICT_PRIO_EN.
- Defined: port 0 has strict priority. When both ports are valid in IDLE, port 0 always wins and the round-robin pointer is unused. Port 1 can starve.
- Undefined: round-robin as specified above.

Test Plan:
- Single source, gigabit: port 0 sends a 4-beat frame 0x11..0x14 with m_trdy=1, IFG_BYTES=12, mii_select=0 -> grant=01 one clk after tvalid; m_tdata shows 0x11..0x14 on consecutive clks; tvalid stays 0 for 12 clk after tlast; busy is high throughout.
- Contention: both ports valid in the same IDLE cycle, each with a 3-beat frame, repeated twice -> grant order is 01, 10, 01, 10 (round-robin); with TX_ARB_STRICT_PRIO_EN -> 01, 01, then 10 only when port 0 is idle.
- Backpressure: m_trdy low for 5 clk mid-frame on beat 0xA5 -> m_tdata holds 0xA5, granted s_trdy=0, non-granted port is never granted during the stall.
- MII gap: mii_select=1, IFG_BYTES=12, port 1 frame ends -> next grant is no earlier than 24 clk plus 1 arbitration clk after the tlast handshake.
- Reset mid-frame: reset_n low for 1 clk during beat 2 of 5 -> next clk grant=00, m_tvalid=0, both trdy=0, state IDLE; after release, a tie is granted to port 0.
- IFG_BYTES=0 build: back-to-back single-beat frames from port 0 -> one frame per 2 clk (XFER + arbitration), no gap.
